// File: rtl/spartan6_dsp.sv
// DSP48A1-style slice: optional D+/-B pre-adder, 18x18 multiplier and 48-bit
// post-adder with X/Z muxes; every stage is a bypassable register with CE and async reset.
module spartan6_dsp #(
    parameter int    SIZE1       = 18,
    parameter int    SIZE2       = 36,
    parameter int    SIZE3       = 48,
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT",
    parameter string RSTTYPE     = "SYNC"
) (
    input  logic             CLK,
    input  logic             RSTA,
    input  logic             RSTB,
    input  logic             RSTC,
    input  logic             RSTD,
    input  logic             RSTM,
    input  logic             RSTP,
    input  logic             RSTCARRYIN,
    input  logic             RSTOPMODE,
    input  logic             CEA,
    input  logic             CEB,
    input  logic             CEC,
    input  logic             CED,
    input  logic             CEM,
    input  logic             CEP,
    input  logic             CECARRYIN,
    input  logic             CEOPMODE,
    input  logic [SIZE1-1:0] A,
    input  logic [SIZE1-1:0] B,
    input  logic [SIZE1-1:0] D,
    input  logic [SIZE1-1:0] BCIN,
    input  logic [SIZE3-1:0] C,
    input  logic [SIZE3-1:0] PCIN,
    input  logic             CARRYIN,
    input  logic [7:0]       OPMODE,
    output logic [SIZE1-1:0] BCOUT,
    output logic [SIZE2-1:0] M,
    output logic [SIZE3-1:0] P,
    output logic [SIZE3-1:0] PCOUT,
    output logic             CARRYOUT,
    output logic             CARRYOUTF
);

    localparam bit use_bcin     = (B_INPUT == "CASCADE");
    localparam bit use_cin_port = (CARRYINSEL == "CARRYIN");
    localparam int DX           = SIZE3 - 2*SIZE1;   // D bits that fit above A:B in the X concat

    logic [SIZE1-1:0] b_src, a0, b0, a1, b1, b1_in, d_r, preadd;
    logic [SIZE3-1:0] c_r, xmux, zmux, p_r;
    logic [SIZE2-1:0] mult, m_r;
    logic [7:0]       opm;
    logic             cin_src, cyi, co_r;
    logic [SIZE3:0]   addend, post_sum;

    // RSTTYPE is kept for source compatibility; every register resets asynchronously regardless.
    generate
        if (RSTTYPE != "SYNC") begin : g_rsttype_async
        end
    endgenerate

    assign b_src = use_bcin ? BCIN : B;

    generate
        if (A0REG != 0) begin : g_a0
            logic [SIZE1-1:0] q;
            always_ff @(posedge CLK or posedge RSTA)
                if (RSTA)     q <= '0;
                else if (CEA) q <= A;
            assign a0 = q;
        end else begin : g_a0_byp
            assign a0 = A;
        end

        if (B0REG != 0) begin : g_b0
            logic [SIZE1-1:0] q;
            always_ff @(posedge CLK or posedge RSTB)
                if (RSTB)     q <= '0;
                else if (CEB) q <= b_src;
            assign b0 = q;
        end else begin : g_b0_byp
            assign b0 = b_src;
        end

        if (DREG != 0) begin : g_d
            logic [SIZE1-1:0] q;
            always_ff @(posedge CLK or posedge RSTD)
                if (RSTD)     q <= '0;
                else if (CED) q <= D;
            assign d_r = q;
        end else begin : g_d_byp
            assign d_r = D;
        end

        if (CREG != 0) begin : g_c
            logic [SIZE3-1:0] q;
            always_ff @(posedge CLK or posedge RSTC)
                if (RSTC)     q <= '0;
                else if (CEC) q <= C;
            assign c_r = q;
        end else begin : g_c_byp
            assign c_r = C;
        end

        if (OPMODEREG != 0) begin : g_opm
            logic [7:0] q;
            always_ff @(posedge CLK or posedge RSTOPMODE)
                if (RSTOPMODE)     q <= '0;
                else if (CEOPMODE) q <= OPMODE;
            assign opm = q;
        end else begin : g_opm_byp
            assign opm = OPMODE;
        end
    endgenerate

    // Pre-adder result is truncated to the operand width.
    assign preadd = opm[6] ? (d_r - b0) : (d_r + b0);
    assign b1_in  = opm[4] ? preadd : b0;

    generate
        if (A1REG != 0) begin : g_a1
            logic [SIZE1-1:0] q;
            always_ff @(posedge CLK or posedge RSTA)
                if (RSTA)     q <= '0;
                else if (CEA) q <= a0;
            assign a1 = q;
        end else begin : g_a1_byp
            assign a1 = a0;
        end

        if (B1REG != 0) begin : g_b1
            logic [SIZE1-1:0] q;
            always_ff @(posedge CLK or posedge RSTB)
                if (RSTB)     q <= '0;
                else if (CEB) q <= b1_in;
            assign b1 = q;
        end else begin : g_b1_byp
            assign b1 = b1_in;
        end
    endgenerate

    assign mult = SIZE2'(a1) * SIZE2'(b1);

    generate
        if (MREG != 0) begin : g_m
            logic [SIZE2-1:0] q;
            always_ff @(posedge CLK or posedge RSTM)
                if (RSTM)     q <= '0;
                else if (CEM) q <= mult;
            assign m_r = q;
        end else begin : g_m_byp
            assign m_r = mult;
        end
    endgenerate

    assign cin_src = use_cin_port ? CARRYIN : opm[5];

    generate
        if (CARRYINREG != 0) begin : g_cyi
            logic q;
            always_ff @(posedge CLK or posedge RSTCARRYIN)
                if (RSTCARRYIN)     q <= 1'b0;
                else if (CECARRYIN) q <= cin_src;
            assign cyi = q;
        end else begin : g_cyi_byp
            assign cyi = cin_src;
        end
    endgenerate

    always_comb begin
        xmux = '0;
        case (opm[1:0])
            2'd0: xmux = '0;
            2'd1: xmux = {{(SIZE3-SIZE2){1'b0}}, m_r};
            2'd2: xmux = p_r;
            2'd3: xmux = {d_r[DX-1:0], a1, b1};
        endcase
    end

    always_comb begin
        zmux = '0;
        case (opm[3:2])
            2'd0: zmux = '0;
            2'd1: zmux = PCIN;
            2'd2: zmux = p_r;
            2'd3: zmux = c_r;
        endcase
    end

    // 49-bit arithmetic: the top bit is the carry when adding and the borrow when subtracting.
    always_comb begin
        addend   = {1'b0, xmux} + {{SIZE3{1'b0}}, cyi};
        post_sum = opm[7] ? ({1'b0, zmux} - addend) : ({1'b0, zmux} + addend);
    end

    generate
        if (PREG != 0) begin : g_p
            logic [SIZE3-1:0] q;
            always_ff @(posedge CLK or posedge RSTP)
                if (RSTP)     q <= '0;
                else if (CEP) q <= post_sum[SIZE3-1:0];
            assign p_r = q;
        end else begin : g_p_byp
            assign p_r = post_sum[SIZE3-1:0];
        end

        if (CARRYOUTREG != 0) begin : g_co
            logic q;
            always_ff @(posedge CLK or posedge RSTP)
                if (RSTP)     q <= 1'b0;
                else if (CEP) q <= post_sum[SIZE3];
            assign co_r = q;
        end else begin : g_co_byp
            assign co_r = post_sum[SIZE3];
        end
    endgenerate

    assign BCOUT     = b1;
    assign M         = m_r;
    assign P         = p_r;
    assign PCOUT     = p_r;
    assign CARRYOUT  = co_r;
    assign CARRYOUTF = co_r;

endmodule

// File: tb/tb_spartan6_dsp.sv
// Self-checking bench for spartan6_dsp: reset, latency sequences, a vector table,
// CE/reset corner cases and randomized steady-state checks against an arithmetic model.
module tb_spartan6_dsp;

    logic        CLK = 1'b0;
    logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
    logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
    logic [17:0] A, B, D, BCIN;
    logic [47:0] C, PCIN;
    logic        CARRYIN;
    logic [7:0]  OPMODE;
    logic [17:0] BCOUT;
    logic [35:0] M;
    logic [47:0] P, PCOUT;
    logic        CARRYOUT, CARRYOUTF;

    int n_chk  = 0;
    int n_fail = 0;

    spartan6_dsp dut (
        .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM),
        .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
        .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
        .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
        .OPMODE(OPMODE), .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT),
        .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  op;
        logic [17:0] a, b, d;
        logic [47:0] c, pcin;
        logic        cy;
        logic [17:0] e_bc;
        logic [35:0] e_m;
        logic [47:0] e_p;
        logic        e_co;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [7:0] op, input logic [17:0] a, b, d,
                                input logic [47:0] c, pcin, input logic cy,
                                input logic [17:0] bc, input logic [35:0] m,
                                input logic [47:0] p, input logic co);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.d = d; v.c = c; v.pcin = pcin; v.cy = cy;
        v.e_bc = bc; v.e_m = m; v.e_p = p; v.e_co = co;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [17:0] bc, input logic [35:0] m,
                              input logic [47:0] p, input logic co);
        check({tag, ".bcout"},     64'(BCOUT),     64'(bc));
        check({tag, ".m"},         64'(M),         64'(m));
        check({tag, ".p"},         64'(P),         64'(p));
        check({tag, ".pcout"},     64'(PCOUT),     64'(p));
        check({tag, ".carryout"},  64'(CARRYOUT),  64'(co));
        check({tag, ".carryoutf"}, 64'(CARRYOUTF), 64'(co));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_rst(input logic v);
        RSTA = v; RSTB = v; RSTC = v; RSTD = v; RSTM = v; RSTP = v; RSTCARRYIN = v; RSTOPMODE = v;
    endtask

    task automatic set_ce(input logic v);
        CEA = v; CEB = v; CEC = v; CED = v; CEM = v; CEP = v; CECARRYIN = v; CEOPMODE = v;
    endtask

    task automatic drive(input logic [7:0] op, input logic [17:0] a, b, d,
                         input logic [47:0] c, pcin, input logic cy);
        OPMODE = op; A = a; B = b; D = d; C = c; PCIN = pcin; CARRYIN = cy;
    endtask

    // Steady-state result of the slice for constant inputs, from the operation rules alone.
    task automatic model(input logic [7:0] op, input longint unsigned a, b, d, c, pcin,
                         output longint unsigned bc, m, p, output logic co);
        longint unsigned b1, x, z, r;
        longint unsigned cin;
        if (op[4]) b1 = (op[6] ? (d - b) : (d + b)) % (64'd1 << 18);
        else       b1 = b;
        m = a * b1;
        case (op[1:0])
            2'd1:    x = m;
            2'd3:    x = (d % 4096) * (64'd1 << 36) + a * (64'd1 << 18) + b1;
            default: x = 0;
        endcase
        case (op[3:2])
            2'd1:    z = pcin;
            2'd3:    z = c;
            default: z = 0;
        endcase
        cin = op[5] ? 64'd1 : 64'd0;
        r   = op[7] ? (z - (x + cin)) : (z + x + cin);
        r   = r % (64'd1 << 49);
        bc  = b1;
        p   = r % (64'd1 << 48);
        co  = (r >= (64'd1 << 48));
    endtask

    initial begin
        vecs[0]  = mk(8'h01, 18'd10, 18'd20, 18'd0, 48'd0, 48'd0, 1'b0, 18'd20, 36'd200, 48'd200, 1'b0);
        vecs[1]  = mk(8'h11, 18'd4, 18'd3, 18'd5, 48'd0, 48'd0, 1'b0, 18'd8, 36'd32, 48'd32, 1'b0);
        vecs[2]  = mk(8'h51, 18'd2, 18'd3, 18'd10, 48'd0, 48'd0, 1'b0, 18'd7, 36'd14, 48'd14, 1'b0);
        vecs[3]  = mk(8'h2D, 18'd3, 18'd4, 18'd0, 48'd100, 48'd0, 1'b0, 18'd4, 36'd12, 48'd113, 1'b0);
        vecs[4]  = mk(8'h8D, 18'd3, 18'd4, 18'd0, 48'd100, 48'd0, 1'b0, 18'd4, 36'd12, 48'd88, 1'b0);
        vecs[5]  = mk(8'h8D, 18'd1, 18'd1, 18'd0, 48'd0, 48'd0, 1'b0, 18'd1, 36'd1, 48'hFFFF_FFFF_FFFF, 1'b1);
        vecs[6]  = mk(8'h03, 18'h12345, 18'h2ABCD, 18'h3FABC, 48'd0, 48'd0, 1'b0, 18'h2ABCD,
                      36'(18'h12345) * 36'(18'h2ABCD), 48'hABC4_8D16_ABCD, 1'b0);
        vecs[7]  = mk(8'h05, 18'd7, 18'd6, 18'd0, 48'd0, 48'd1000, 1'b0, 18'd6, 36'd42, 48'd1042, 1'b0);
        vecs[8]  = mk(8'h51, 18'd1, 18'd5, 18'd3, 48'd0, 48'd0, 1'b0, 18'h3FFFE, 36'h3FFFE, 48'h3FFFE, 1'b0);
        vecs[9]  = mk(8'h01, 18'h3FFFF, 18'h3FFFF, 18'd0, 48'd0, 48'd0, 1'b0, 18'h3FFFF,
                      36'hF_FFF8_0001, 48'hF_FFF8_0001, 1'b0);
        vecs[10] = mk(8'h0D, 18'd3, 18'd4, 18'd0, 48'd100, 48'd0, 1'b1, 18'd4, 36'd12, 48'd112, 1'b0);
        vecs[11] = mk(8'h2C, 18'd0, 18'd0, 18'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 1'b0, 18'd0, 36'd0, 48'd0, 1'b1);
        vecs[12] = mk(8'hAD, 18'd3, 18'd4, 18'd0, 48'd13, 48'd0, 1'b0, 18'd4, 36'd12, 48'd0, 1'b0);

        // Full reset with random inputs, before and after clock edges
        set_ce(1'b1);
        set_rst(1'b1);
        BCIN = 18'($urandom);
        drive(8'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
              {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)}, 1'($urandom));
        #1;
        check_outs("reset_async", 18'd0, 36'd0, 48'd0, 1'b0);
        tick(2);
        check_outs("reset_clocked", 18'd0, 36'd0, 48'd0, 1'b0);
        set_rst(1'b0);
        BCIN = '0;

        // Multiply-only latency
        drive(8'h01, 18'd10, 18'd20, 18'd0, 48'd0, 48'd0, 1'b0);
        tick(1); check("mul_lat.bcout_e1", 64'(BCOUT), 64'd20);
        tick(1); check("mul_lat.m_e2",     64'(M),     64'd200);
        tick(1); check("mul_lat.p_e3",     64'(P),     64'd200);
        check("mul_lat.pcout_e3", 64'(PCOUT), 64'd200);
        check("mul_lat.co_e3",    64'(CARRYOUT), 64'd0);

        // Mid-operation RSTM clears M only; P keeps its value and the pipe refills
        tick(2);
        RSTM = 1'b1; #1;
        check("rstm.m_async", 64'(M), 64'd0);
        check("rstm.p_kept",  64'(P), 64'd200);
        RSTM = 1'b0;
        tick(1);
        check("rstm.m_refill", 64'(M), 64'd200);
        check("rstm.p_sees_0", 64'(P), 64'd0);
        tick(1);
        check("rstm.p_refill", 64'(P), 64'd200);

        // Pre-adder path latency
        drive(8'h11, 18'd4, 18'd3, 18'd5, 48'd0, 48'd0, 1'b0);
        tick(2); check("pre_lat.bcout_e2", 64'(BCOUT), 64'd8);
        tick(1); check("pre_lat.m_e3",     64'(M),     64'd32);
        tick(1); check("pre_lat.p_e4",     64'(P),     64'd32);

        // Vector table, steady state
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].c, vecs[i].pcin, vecs[i].cy);
            tick(5);
            check_outs($sformatf("vec%0d", i), vecs[i].e_bc, vecs[i].e_m, vecs[i].e_p, vecs[i].e_co);
        end

        // Accumulator: P += A*B each cycle once M is valid
        set_rst(1'b1); #1; set_rst(1'b0);
        drive(8'h09, 18'd2, 18'd3, 18'd0, 48'd0, 48'd0, 1'b0);
        tick(3); check("acc.p_e3", 64'(P), 64'd6);
        tick(1); check("acc.p_e4", 64'(P), 64'd12);
        tick(1); check("acc.p_e5", 64'(P), 64'd18);

        // Post-subtract, borrow, CEP hold, async RSTP
        drive(8'h8D, 18'd3, 18'd4, 18'd0, 48'd100, 48'd0, 1'b0);
        tick(5);
        check("sub.p",  64'(P), 64'd88);
        check("sub.co", 64'(CARRYOUT), 64'd0);
        drive(8'h8D, 18'd1, 18'd1, 18'd0, 48'd0, 48'd0, 1'b0);
        tick(5);
        check("borrow.p",   64'(P),         64'hFFFF_FFFF_FFFF);
        check("borrow.co",  64'(CARRYOUT),  64'd1);
        check("borrow.cof", 64'(CARRYOUTF), 64'd1);
        CEP = 1'b0;
        drive(8'h8D, 18'd5, 18'd5, 18'd0, 48'd7, 48'd0, 1'b0);
        tick(5);
        check("cep_hold.p",  64'(P),        64'hFFFF_FFFF_FFFF);
        check("cep_hold.co", 64'(CARRYOUT), 64'd1);
        check("cep_hold.m",  64'(M),        64'd25);
        RSTP = 1'b1; #1;
        check("rstp.p",     64'(P),        64'd0);
        check("rstp.pcout", 64'(PCOUT),    64'd0);
        check("rstp.co",    64'(CARRYOUT), 64'd0);
        RSTP = 1'b0;
        CEP  = 1'b1;
        tick(1);

        // Randomized steady-state checks against the arithmetic model
        for (int k = 0; k < 40; k++) begin
            logic [7:0]      op;
            int              xs, zs;
            longint unsigned e_bc, e_m, e_p;
            logic            e_co;
            xs = int'($urandom_range(0, 2)); if (xs == 2) xs = 3;
            zs = int'($urandom_range(0, 2)); if (zs == 2) zs = 3;
            op = {1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'(zs), 2'(xs)};
            drive(op, 18'($urandom), 18'($urandom), 18'($urandom),
                  {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)}, 1'($urandom));
            tick(5);
            model(op, 64'(A), 64'(B), 64'(D), 64'(C), 64'(PCIN), e_bc, e_m, e_p, e_co);
            check_outs($sformatf("rnd%0d_op%02h", k, op), 18'(e_bc), 36'(e_m), 48'(e_p), e_co);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
